// File: rtl/vga_timing_pkg.sv
// VGA timing package: 640x480@60 default constants, raster state enum and
// the colour-bar palette used by the optional test-pattern generator
// (enabled with VGA_SYNC_TEST_PATTERN_EN).
package vga_timing_pkg;

    // Default 640x480@60 timing (pixel clock 25.2 MHz)
    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_SYNC_POL    = 0;
    localparam int DEF_LOCK_SETTLE = 1024;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Raster counters are 10 bits wide, so totals are limited to 1024
    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1024;

    // Raster state
    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } vga_state_t;

    // Colour bars, left to right
    localparam int          N_BARS      = 8;
    localparam logic [23:0] COL_WHITE   = 24'hFF_FF_FF;
    localparam logic [23:0] COL_YELLOW  = 24'hFF_FF_00;
    localparam logic [23:0] COL_CYAN    = 24'h00_FF_FF;
    localparam logic [23:0] COL_GREEN   = 24'h00_FF_00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF_00_FF;
    localparam logic [23:0] COL_RED     = 24'hFF_00_00;
    localparam logic [23:0] COL_BLUE    = 24'h00_00_FF;
    localparam logic [23:0] COL_BLACK   = 24'h00_00_00;

    // Map a bar index (0 = leftmost) to its colour
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] col;
        case (idx)
            3'd0:    col = COL_WHITE;
            3'd1:    col = COL_YELLOW;
            3'd2:    col = COL_CYAN;
            3'd3:    col = COL_GREEN;
            3'd4:    col = COL_MAGENTA;
            3'd5:    col = COL_RED;
            3'd6:    col = COL_BLUE;
            3'd7:    col = COL_BLACK;
            default: col = COL_BLACK;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/vga_lock_settle.sv
// PLL lock qualifier: two-flop synchroniser for the asynchronous lock input
// followed by a settle counter. lock_ok is high only once the synchronised
// lock has been continuously high for LOCK_SETTLE clocks, and drops in the
// same cycle the synchronised lock drops.
module vga_lock_settle
    import vga_timing_pkg::*;
#(
    parameter int LOCK_SETTLE = DEF_LOCK_SETTLE
) (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    output logic lock_ok
);

    localparam int                    SETTLE_W    = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
    localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(LOCK_SETTLE - 1);

    generate
        if (LOCK_SETTLE < 1) begin : g_bad_settle
            $error("vga_lock_settle: LOCK_SETTLE must be at least 1");
        end
    endgenerate

    logic                lk_meta_q;
    logic                lk_s_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] settle_d;

    // Two-flop synchroniser bringing the PLL lock into the pixel clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
        end else begin
            lk_meta_q <= locked;
            lk_s_q    <= lk_meta_q;
        end
    end

    // Settle count: cleared while unlocked, counts up and saturates while locked
    always_comb begin
        settle_d = settle_q;
        if (!lk_s_q) begin
            settle_d = '0;
        end else if (settle_q != SETTLE_LAST) begin
            settle_d = settle_q + SETTLE_W'(1);
        end else begin
            settle_d = settle_q;
        end
    end

    // Settle counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q <= '0;
        end else begin
            settle_q <= settle_d;
        end
    end

    assign lock_ok = lk_s_q && (settle_q == SETTLE_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator (640x480@60 by default). Waits for a settled
// PLL lock, then runs horizontal/vertical counters and decodes sync, data
// enable, pixel coordinates and line/frame strobes. All outputs are
// registered once from the counter decode so they stay mutually aligned.
// Define VGA_SYNC_TEST_PATTERN_EN to add a 24-bit colour-bar output (rgb).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int SYNC_POL    = DEF_SYNC_POL,
    parameter int LOCK_SETTLE = DEF_LOCK_SETTLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic             running
`ifdef VGA_SYNC_TEST_PATTERN_EN
    ,
    output logic [23:0]      rgb
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW1     = CNT_W + 1;

    // Decode thresholds, one bit wider than the counters so that a value of
    // exactly 1024 still compares correctly
    localparam logic [CW1-1:0]   H_ACT_C   = CW1'(H_ACTIVE);
    localparam logic [CW1-1:0]   HS_BEG_C  = CW1'(H_ACTIVE + H_FP);
    localparam logic [CW1-1:0]   HS_END_C  = CW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW1-1:0]   V_ACT_C   = CW1'(V_ACTIVE);
    localparam logic [CW1-1:0]   VS_BEG_C  = CW1'(V_ACTIVE + V_FP);
    localparam logic [CW1-1:0]   VS_END_C  = CW1'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic             SYNC_ACT  = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    generate
        if ((H_TOTAL > CNT_MAX) || (V_TOTAL > CNT_MAX)) begin : g_bad_total
            $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    logic             lock_ok_s;
    vga_state_t       state_q;
    logic [CNT_W-1:0] h_cnt_q;
    logic [CNT_W-1:0] v_cnt_q;

    logic             hsync_d, vsync_d, de_d, line_start_d, frame_start_d, running_d;
    logic [CNT_W-1:0] x_d, y_d;
    logic             hsync_q, vsync_q, de_q, line_start_q, frame_start_q, running_q;
    logic [CNT_W-1:0] x_q, y_q;

    vga_lock_settle #(
        .LOCK_SETTLE (LOCK_SETTLE)
    ) u_lock_settle (
        .clk     (clk),
        .rst     (rst),
        .locked  (locked),
        .lock_ok (lock_ok_s)
    );

    // Raster FSM and counters; counters are held at zero outside RUN so a
    // fresh RUN always begins at the top-left of a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                    if (lock_ok_s) begin
                        state_q <= RUN;
                    end else begin
                        state_q <= WAIT_LOCK;
                    end
                end
                RUN: begin
                    if (!lock_ok_s) begin
                        state_q <= WAIT_LOCK;
                        h_cnt_q <= '0;
                        v_cnt_q <= '0;
                    end else if (h_cnt_q == H_LAST) begin
                        state_q <= RUN;
                        h_cnt_q <= '0;
                        if (v_cnt_q == V_LAST) begin
                            v_cnt_q <= '0;
                        end else begin
                            v_cnt_q <= v_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_q <= RUN;
                        h_cnt_q <= h_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= WAIT_LOCK;
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                end
            endcase
        end
    end

    // Timing decode from the current counter values
    always_comb begin
        logic run_s, h_act_s, v_act_s, hs_act_s, vs_act_s;
        run_s    = (state_q == RUN);
        h_act_s  = ({1'b0, h_cnt_q} <  H_ACT_C);
        v_act_s  = ({1'b0, v_cnt_q} <  V_ACT_C);
        hs_act_s = ({1'b0, h_cnt_q} >= HS_BEG_C) && ({1'b0, h_cnt_q} < HS_END_C);
        vs_act_s = ({1'b0, v_cnt_q} >= VS_BEG_C) && ({1'b0, v_cnt_q} < VS_END_C);

        de_d          = run_s && h_act_s && v_act_s;
        x_d           = de_d ? h_cnt_q : '0;
        y_d           = de_d ? v_cnt_q : '0;
        hsync_d       = (run_s && hs_act_s) ? SYNC_ACT : ~SYNC_ACT;
        vsync_d       = (run_s && vs_act_s) ? SYNC_ACT : ~SYNC_ACT;
        line_start_d  = run_s && (h_cnt_q == '0);
        frame_start_d = run_s && (h_cnt_q == '0) && (v_cnt_q == '0);
        running_d     = run_s;
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q       <= ~SYNC_ACT;
            vsync_q       <= ~SYNC_ACT;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;

`ifdef VGA_SYNC_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / N_BARS;

    logic [2:0]  bar_idx_s;
    logic [23:0] rgb_d;
    logic [23:0] rgb_q;

    // Bar index: number of bar boundaries the current column has passed
    always_comb begin
        bar_idx_s = 3'd0;
        for (int k = 1; k < N_BARS; k++) begin
            if ({1'b0, h_cnt_q} >= CW1'(k * BAR_W)) begin
                bar_idx_s = bar_idx_s + 3'd1;
            end else begin
                bar_idx_s = bar_idx_s;
            end
        end
        rgb_d = de_d ? bar_colour(bar_idx_s) : 24'h00_00_00;
    end

    // Colour register, aligned with de
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= 24'h00_00_00;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed self-checking bench for vga_sync_gen. Instance d uses the default
// 640x480 timing (settle, horizontal line); instance s uses a reduced raster
// (40+4+8+8 by 20+2+2+3, settle 16) so full frames, lock loss and reset
// recovery fit in a short run.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst;
    logic locked;

    logic       d_hsync, d_vsync, d_de, d_line_start, d_frame_start, d_running;
    logic [9:0] d_x, d_y;
    logic       s_hsync, s_vsync, s_de, s_line_start, s_frame_start, s_running;
    logic [9:0] s_x, s_y;
`ifdef VGA_SYNC_TEST_PATTERN_EN
    logic [23:0] d_rgb, s_rgb;
`endif

    int errors = 0;
    int checks = 0;

    int d_fs_n, s_fs_n, s_run_n, s_de_n, early_hs, idle_bad, loss_n, partial;
    int de_cnt, hs_cnt, hs_first, x_bad, y_bad, ls_bad, ls_cnt, vs_cnt, vs_first, y_max;
    logic [9:0] first_x, first_y;

    always #5 clk = ~clk;

    vga_sync_gen u_d (
        .clk         (clk),
        .rst         (rst),
        .locked      (locked),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .de          (d_de),
        .x           (d_x),
        .y           (d_y),
        .line_start  (d_line_start),
        .frame_start (d_frame_start),
        .running     (d_running)
`ifdef VGA_SYNC_TEST_PATTERN_EN
        ,
        .rgb         (d_rgb)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE (40), .H_FP (4), .H_SYNC (8), .H_BP (8),
        .V_ACTIVE (20), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (0), .LOCK_SETTLE (16)
    ) u_s (
        .clk         (clk),
        .rst         (rst),
        .locked      (locked),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .de          (s_de),
        .x           (s_x),
        .y           (s_y),
        .line_start  (s_line_start),
        .frame_start (s_frame_start),
        .running     (s_running)
`ifdef VGA_SYNC_TEST_PATTERN_EN
        ,
        .rgb         (s_rgb)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic d_idle();
        return (d_hsync === 1'b1) && (d_vsync === 1'b1) && (d_de === 1'b0) &&
               (d_x === 10'd0) && (d_y === 10'd0) && (d_line_start === 1'b0) &&
               (d_frame_start === 1'b0) && (d_running === 1'b0);
    endfunction

    function automatic logic s_idle();
        return (s_hsync === 1'b1) && (s_vsync === 1'b1) && (s_de === 1'b0) &&
               (s_x === 10'd0) && (s_y === 10'd0) && (s_line_start === 1'b0) &&
               (s_frame_start === 1'b0) && (s_running === 1'b0);
    endfunction

    // Wait (bounded) until instance s shows pixel (xx, yy) with de high
    task automatic wait_px(input string tag, input logic [9:0] yy, input logic [9:0] xx);
        int n;
        n = 0;
        while ((n < 4000) && !((s_de === 1'b1) && (s_y === yy) && (s_x === xx))) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 4000), 32'd1);
    endtask

    // Count clocks from now until instance s emits frame_start (0 if none within 100)
    task automatic measure_s_restart(output int fs_n);
        fs_n = 0;
        for (int n = 1; (n <= 100) && (fs_n == 0); n++) begin
            @(negedge clk);
            if (s_frame_start === 1'b1) fs_n = n;
        end
    endtask

    initial begin
        // ---------------- reset with lock present ----------------
        rst    = 1'b1;
        locked = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_d_idle", 32'(d_idle()), 32'd1);
            chk("rst_s_idle", 32'(s_idle()), 32'd1);
        end
        chk("rst_hsync", 32'(d_hsync), 32'd1);
        chk("rst_vsync", 32'(d_vsync), 32'd1);

        // ---------------- idle while unlocked ----------------
        locked   = 1'b0;
        rst      = 1'b0;
        idle_bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (!d_idle() || !s_idle()) idle_bad++;
        end
        chk("unlocked_idle", 32'(idle_bad), 32'd0);

        // ---------------- settle ----------------
        // 2 sync clocks, LOCK_SETTLE-1 further clocks to reach the last count,
        // 1 clock into RUN, 1 output register: LOCK_SETTLE + 3
        locked   = 1'b1;
        d_fs_n   = 0;
        s_fs_n   = 0;
        s_run_n  = 0;
        early_hs = 0;
        for (int n = 1; (n <= 1100) && (d_fs_n == 0); n++) begin
            @(negedge clk);
            if ((d_frame_start === 1'b1) && (d_fs_n == 0)) d_fs_n = n;
            if ((s_frame_start === 1'b1) && (s_fs_n == 0)) s_fs_n = n;
            if ((s_running === 1'b1) && (s_run_n == 0)) s_run_n = n;
            if ((d_fs_n == 0) && (d_hsync !== 1'b1)) early_hs++;
        end
        chk("settle_d_frame_start_cycle", 32'(d_fs_n), 32'd1027);
        chk("settle_s_frame_start_cycle", 32'(s_fs_n), 32'd19);
        chk("settle_s_running_cycle", 32'(s_run_n), 32'd19);
        chk("settle_no_early_hsync", 32'(early_hs), 32'd0);
        chk("settle_d_running", 32'(d_running), 32'd1);
        chk("settle_d_line_start", 32'(d_line_start), 32'd1);

        // ---------------- one default line (800 clocks) ----------------
        de_cnt = 0; hs_cnt = 0; hs_first = -1; x_bad = 0; y_bad = 0; ls_bad = 0;
        for (int k = 0; k < 800; k++) begin
            if (d_de === 1'b1) de_cnt++;
            if (d_hsync === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
            if (d_x !== ((k < 640) ? 10'(k) : 10'd0)) x_bad++;
            if (d_y !== 10'd0) y_bad++;
            if ((k > 0) && (d_line_start !== 1'b0)) ls_bad++;
            @(negedge clk);
        end
        chk("line_de_count", 32'(de_cnt), 32'd640);
        chk("line_hsync_low_count", 32'(hs_cnt), 32'd96);
        chk("line_hsync_offset", 32'(hs_first), 32'd656);
        chk("line_x_sequence", 32'(x_bad), 32'd0);
        chk("line_y_zero", 32'(y_bad), 32'd0);
        chk("line_no_extra_line_start", 32'(ls_bad), 32'd0);
        chk("line_period_line_start", 32'(d_line_start), 32'd1);
        chk("line_period_no_frame_start", 32'(d_frame_start), 32'd0);
        chk("line1_y", 32'(d_y), 32'd1);

        // ---------------- one reduced frame (60 x 27 = 1620 clocks) ----------------
        for (int n = 0; (n < 2000) && (s_frame_start !== 1'b1); n++) @(negedge clk);
        chk("frame_found", 32'(s_frame_start), 32'd1);
        ls_cnt = 0; de_cnt = 0; vs_cnt = 0; vs_first = -1; y_max = 0;
        ls_bad = 0; hs_first = -1; x_bad = 0; y_bad = 0;
        for (int k = 0; k < 1620; k++) begin
            if (s_line_start === 1'b1) ls_cnt++;
            if (s_de === 1'b1) begin
                de_cnt++;
                if (int'(s_y) > y_max) y_max = int'(s_y);
                if (s_x !== 10'(k % 60)) x_bad++;
                if (s_y !== 10'(k / 60)) y_bad++;
            end
            if (s_vsync === 1'b0) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = k;
            end
            if ((k < 60) && (s_hsync === 1'b0) && (hs_first < 0)) hs_first = k;
            if ((k > 0) && (s_frame_start !== 1'b0)) ls_bad++;
            @(negedge clk);
        end
        chk("frame_line_starts", 32'(ls_cnt), 32'd27);
        chk("frame_de_count", 32'(de_cnt), 32'd800);
        chk("frame_y_max", 32'(y_max), 32'd19);
        chk("frame_x_values", 32'(x_bad), 32'd0);
        chk("frame_y_values", 32'(y_bad), 32'd0);
        chk("frame_vsync_low_count", 32'(vs_cnt), 32'd120);
        chk("frame_vsync_offset", 32'(vs_first), 32'd1320);
        chk("frame_hsync_offset", 32'(hs_first), 32'd44);
        chk("frame_no_extra_frame_start", 32'(ls_bad), 32'd0);
        chk("frame_period", 32'(s_frame_start), 32'd1);

        // ---------------- lock loss mid-frame ----------------
        // 2 sync clocks, 1 clock to WAIT_LOCK, 1 output register
        wait_px("loss_wait_px", 10'd10, 10'd15);
        locked = 1'b0;
        loss_n = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if ((loss_n == 0) && s_idle()) loss_n = n;
        end
        chk("loss_latency", 32'(loss_n), 32'd4);
        chk("loss_d_idle", 32'(d_idle()), 32'd1);
        idle_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!s_idle()) idle_bad++;
        end
        chk("loss_hold_idle", 32'(idle_bad), 32'd0);

        // ---------------- relock: full settle, frame restarts from 0,0 ----------------
        locked  = 1'b1;
        s_fs_n  = 0; s_run_n = 0; s_de_n = 0; partial = 0;
        first_x = 10'h3FF; first_y = 10'h3FF;
        for (int n = 1; (n <= 100) && (s_fs_n == 0); n++) begin
            @(negedge clk);
            if ((s_running === 1'b1) && (s_run_n == 0)) s_run_n = n;
            if ((s_de === 1'b1) && (s_de_n == 0)) begin
                s_de_n  = n;
                first_x = s_x;
                first_y = s_y;
            end
            if (s_frame_start === 1'b1) s_fs_n = n;
            if ((s_fs_n == 0) && (s_de === 1'b1)) partial++;
        end
        chk("relock_frame_start_cycle", 32'(s_fs_n), 32'd19);
        chk("relock_running_cycle", 32'(s_run_n), 32'd19);
        chk("relock_first_de_cycle", 32'(s_de_n), 32'd19);
        chk("relock_first_x", 32'(first_x), 32'd0);
        chk("relock_first_y", 32'(first_y), 32'd0);
        chk("relock_no_partial", 32'(partial), 32'd0);

        // ---------------- rst mid-frame ----------------
        wait_px("rst_wait_px", 10'd5, 10'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_s_idle", 32'(s_idle()), 32'd1);
        chk("midrst_d_idle", 32'(d_idle()), 32'd1);
        rst = 1'b0;
        measure_s_restart(s_fs_n);
        chk("midrst_restart_cycle", 32'(s_fs_n), 32'd19);

`ifdef VGA_SYNC_TEST_PATTERN_EN
        // ---------------- colour bars (bar width 5) ----------------
        wait_px("rgb_wait_x0", 10'd3, 10'd0);
        chk("rgb_white", 32'(s_rgb), 32'hFFFFFF);
        wait_px("rgb_wait_x5", 10'd3, 10'd5);
        chk("rgb_yellow", 32'(s_rgb), 32'hFFFF00);
        wait_px("rgb_wait_x10", 10'd3, 10'd10);
        chk("rgb_cyan", 32'(s_rgb), 32'h00FFFF);
        wait_px("rgb_wait_x30", 10'd3, 10'd30);
        chk("rgb_blue", 32'(s_rgb), 32'h0000FF);
        wait_px("rgb_wait_x35", 10'd3, 10'd35);
        chk("rgb_black", 32'(s_rgb), 32'h000000);
        wait_px("rgb_wait_x39", 10'd3, 10'd39);
        @(negedge clk);
        chk("rgb_blank_de", 32'(s_de), 32'd0);
        chk("rgb_blank", 32'(s_rgb), 32'h000000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #5000000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
